// File: rtl/output_buffer_drain_if.sv
// Downstream beat stream of the output buffer drain: payload, handshake and
// the slot/beat position of the beat currently offered.
interface output_buffer_drain_if #(
  parameter int DATA_W = 32
);
  logic [63:0][DATA_W-1:0] out_data;
  logic [3:0][DATA_W-1:0]  out_scalar;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_last;
  logic [4:0]              pe_idx;
  logic [3:0]              data_idx;

  // Drain side: produces beats and consumes the ready
  modport master (
    output out_data, out_scalar, out_valid, out_last, pe_idx, data_idx,
    input  out_ready
  );

  // Consumer side: takes beats and produces the ready
  modport slave (
    input  out_data, out_scalar, out_valid, out_last, pe_idx, data_idx,
    output out_ready
  );
endinterface

// File: rtl/output_buffer_drain.sv
// Read-side controller of the 4-MLB output buffer. A start pulse sweeps every
// (sub, unit) slot in order: read the slot, capture the 64-word result, then
// stream it downstream as one wide beat or as sixteen 4-word scalar beats.
module output_buffer_drain #(
  parameter int DATA_W   = 32,
  parameter int NUM_SUB  = 4,
  parameter int NUM_UNIT = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic                    is_scalar_i,
  output logic                    output_read_en_o,
  output logic [1:0]              sub_tile_idx_o,
  output logic [2:0]              unit_tile_idx_o,
  input  logic [63:0][DATA_W-1:0] buf_out_i,
  output logic                    busy_o,
  output logic                    done_o,
  output_buffer_drain_if.master   out_if
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    CAP,
    SEND,
    FIN
  } state_t;

  localparam logic [1:0] LastSub  = 2'(NUM_SUB - 1);
  localparam logic [2:0] LastUnit = 3'(NUM_UNIT - 1);

  state_t                  state_q, state_d;
  logic                    scalar_q, scalar_d;
  logic [1:0]              sub_q, sub_d;
  logic [2:0]              unit_q, unit_d;
  logic [3:0]              didx_q, didx_d;
  logic [63:0][DATA_W-1:0] hold_q, hold_d;

  logic                    xfer;
  logic                    slot_done;
  logic                    last_slot;

  assign xfer      = (state_q == SEND) && out_if.out_ready;
  assign slot_done = !scalar_q || (didx_q == 4'd15);
  assign last_slot = (sub_q == LastSub) && (unit_q == LastUnit);

  // State, mode, slot position and holding register; reset wipes everything
  // so a drain interrupted mid-way leaves no stale data or pending done
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      scalar_q <= 1'b0;
      sub_q    <= '0;
      unit_q   <= '0;
      didx_q   <= '0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      scalar_q <= scalar_d;
      sub_q    <= sub_d;
      unit_q   <= unit_d;
      didx_q   <= didx_d;
      hold_q   <= hold_d;
    end
  end

  // Next-state sweep: read, capture, send beats, then advance unit, then sub
  always_comb begin
    state_d  = state_q;
    scalar_d = scalar_q;
    sub_d    = sub_q;
    unit_d   = unit_q;
    didx_d   = didx_q;
    hold_d   = hold_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          scalar_d = is_scalar_i;
          sub_d    = '0;
          unit_d   = '0;
          didx_d   = '0;
          state_d  = RD;
        end
      end
      RD: begin
        state_d = CAP;
      end
      CAP: begin
        hold_d  = buf_out_i;
        state_d = SEND;
      end
      SEND: begin
        if (xfer) begin
          if (!slot_done) begin
            didx_d = didx_q + 4'd1;
          end else begin
            didx_d = '0;
            if (unit_q != LastUnit) begin
              unit_d  = unit_q + 3'd1;
              state_d = RD;
            end else begin
              unit_d = '0;
              if (sub_q != LastSub) begin
                sub_d   = sub_q + 2'd1;
                state_d = RD;
              end else begin
                state_d = FIN;
              end
            end
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Scalar beat picks word data_idx from each 16-word quarter of the slot,
  // matching the lane layout the buffer uses for scalar writes
  always_comb begin
    out_if.out_scalar = '0;
    if ((state_q == SEND) && scalar_q) begin
      for (int k = 0; k < 4; k++) begin
        out_if.out_scalar[k] = hold_q[{2'(k), didx_q}];
      end
    end
  end

  assign out_if.out_data  = ((state_q == SEND) && !scalar_q) ? hold_q : '0;
  assign out_if.out_valid = (state_q == SEND);
  assign out_if.out_last  = (state_q == SEND) && last_slot && slot_done;
  assign out_if.pe_idx    = {sub_q, unit_q};
  assign out_if.data_idx  = didx_q;

  assign output_read_en_o = (state_q == RD);
  assign sub_tile_idx_o   = sub_q;
  assign unit_tile_idx_o  = unit_q;
  assign busy_o           = (state_q == RD) || (state_q == CAP) || (state_q == SEND);
  assign done_o           = (state_q == FIN);

endmodule

// File: tb/tb_output_buffer_drain.sv
// Directed bench for output_buffer_drain: wide and scalar drains against a
// registered buffer model, backpressure, ignored restart and mid-drain reset.
module tb_output_buffer_drain;

  logic                clk;
  logic                rst;
  logic                start;
  logic                isScalar;
  logic                readEn;
  logic [1:0]          subIdx;
  logic [2:0]          unitIdx;
  logic [63:0][31:0]   bufOut;
  logic                busy;
  logic                done;

  int checks;
  int failures;

  output_buffer_drain_if #(.DATA_W(32)) sif ();

  output_buffer_drain #(
    .DATA_W  (32),
    .NUM_SUB (4),
    .NUM_UNIT(8)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start_i         (start),
    .is_scalar_i     (isScalar),
    .output_read_en_o(readEn),
    .sub_tile_idx_o  (subIdx),
    .unit_tile_idx_o (unitIdx),
    .buf_out_i       (bufOut),
    .busy_o          (busy),
    .done_o          (done),
    .out_if          (sif)
  );

  // Free-running clock, 10 time units per cycle
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Word i of slot pe reads back as {pe, i}
  function automatic logic [31:0] word(input int pe, input int i);
    return 32'(pe * 256 + i);
  endfunction

  // Buffer model: data valid exactly one cycle after a read, junk otherwise
  always @(posedge clk) begin
    if (readEn) begin
      for (int i = 0; i < 64; i++) bufOut[i] <= word(int'({subIdx, unitIdx}), i);
    end else begin
      bufOut <= {64{32'hDEADBEEF}};
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    isScalar = 1'b0;
    sif.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (sif.out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || readEn !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_ctrl: valid=%b busy=%b done=%b rd=%b, required all 0",
               sif.out_valid, busy, done, readEn);
    end
    checks++;
    if (sif.pe_idx !== 5'd0 || sif.data_idx !== 4'd0 || subIdx !== 2'd0 || unitIdx !== 3'd0) begin
      failures++;
      $display("[TB] FAIL reset_idx: pe=%0d d=%0d sub=%0d unit=%0d, required 0",
               sif.pe_idx, sif.data_idx, subIdx, unitIdx);
    end
    checks++;
    if (sif.out_data !== '0 || sif.out_scalar !== '0 || sif.out_last !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_payload: payload or last nonzero, required 0");
    end
    rst = 1'b0;
    sif.out_ready = 1'b1;
    @(negedge clk);
  endtask

  // Wide drain; stallSlot >= 0 holds out_ready low for 3 cycles on that slot
  task automatic test_wide_drain(input int stallSlot);
    int cyc, beats, reads, stalls, slotXfers, doneCyc;
    bit seenDone;
    logic [63:0][31:0] snap, expData;
    cyc = 0; beats = 0; reads = 0; stalls = 0; slotXfers = 0; doneCyc = 0;
    seenDone = 1'b0;
    snap = '0;
    isScalar = 1'b0;
    sif.out_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!seenDone && cyc < 400) begin
      if (readEn) begin
        checks++;
        if (int'(subIdx) != reads / 8 || int'(unitIdx) != reads % 8) begin
          failures++;
          $display("[TB] FAIL wide_read_order: sub/unit=%0d/%0d, required %0d/%0d",
                   subIdx, unitIdx, reads / 8, reads % 8);
        end
        reads++;
      end
      if (sif.out_valid) begin
        for (int i = 0; i < 64; i++) expData[i] = word(beats, i);
        checks++;
        if (int'(sif.pe_idx) != beats || sif.data_idx !== 4'd0) begin
          failures++;
          $display("[TB] FAIL wide_index: pe=%0d d=%0d, required %0d/0",
                   sif.pe_idx, sif.data_idx, beats);
        end
        checks++;
        if (sif.out_data !== expData) begin
          failures++;
          $display("[TB] FAIL wide_data: word63=%h word0=%h, required %h %h",
                   sif.out_data[63], sif.out_data[0], expData[63], expData[0]);
        end
        checks++;
        if (sif.out_last !== (beats == 31)) begin
          failures++;
          $display("[TB] FAIL wide_last: last=%b on beat %0d, required %b",
                   sif.out_last, beats, (beats == 31));
        end
        if (beats == stallSlot && stalls > 0) begin
          checks++;
          if (sif.out_data !== snap || readEn !== 1'b0) begin
            failures++;
            $display("[TB] FAIL stall_hold: data changed or read issued (rd=%b), required stable",
                     readEn);
          end
        end
        snap = sif.out_data;
        if (beats == stallSlot && stalls < 3) begin
          sif.out_ready = 1'b0;
          stalls++;
        end else begin
          sif.out_ready = 1'b1;
          if (beats == stallSlot) slotXfers++;
          beats++;
        end
      end else begin
        sif.out_ready = 1'b1;
      end
      checks++;
      if (busy !== !done) begin
        failures++;
        $display("[TB] FAIL wide_busy: busy=%b done=%b at cycle %0d, required busy=~done",
                 busy, done, cyc);
      end
      if (done) begin
        seenDone = 1'b1;
        doneCyc = cyc;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    checks++;
    if (!seenDone) begin
      failures++;
      $display("[TB] FAIL wide_timeout: no done after %0d cycles, required done", cyc);
    end
    checks++;
    if (beats != 32 || reads != 32) begin
      failures++;
      $display("[TB] FAIL wide_counts: beats=%0d reads=%0d, required 32/32", beats, reads);
    end
    checks++;
    if (doneCyc != ((stallSlot >= 0) ? 100 : 97)) begin
      failures++;
      $display("[TB] FAIL wide_latency: done at %0d, required %0d",
               doneCyc, (stallSlot >= 0) ? 100 : 97);
    end
    if (stallSlot >= 0) begin
      checks++;
      if (slotXfers != 1 || stalls != 3) begin
        failures++;
        $display("[TB] FAIL stall_xfer: slot transfers=%0d stalls=%0d, required 1/3",
                 slotXfers, stalls);
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL wide_done_pulse: done=%b busy=%b after done, required 0/0", done, busy);
    end
  endtask

  task automatic test_backpressure();
    test_wide_drain(4);
  endtask

  task automatic test_scalar_drain();
    int cyc, beats, reads, doneCyc, slot, d;
    bit seenDone;
    logic [3:0][31:0] expScalar;
    cyc = 0; beats = 0; reads = 0; doneCyc = 0;
    seenDone = 1'b0;
    isScalar = 1'b1;
    sif.out_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    isScalar = 1'b0;
    cyc = 1;
    while (!seenDone && cyc < 2000) begin
      if (readEn) begin
        checks++;
        if (int'(subIdx) != reads / 8 || int'(unitIdx) != reads % 8) begin
          failures++;
          $display("[TB] FAIL scalar_read_order: sub/unit=%0d/%0d, required %0d/%0d",
                   subIdx, unitIdx, reads / 8, reads % 8);
        end
        reads++;
      end
      if (sif.out_valid) begin
        slot = beats / 16;
        d = beats % 16;
        for (int k = 0; k < 4; k++) expScalar[k] = word(slot, 16 * k + d);
        checks++;
        if (int'(sif.pe_idx) != slot || int'(sif.data_idx) != d) begin
          failures++;
          $display("[TB] FAIL scalar_index: pe=%0d d=%0d, required %0d/%0d",
                   sif.pe_idx, sif.data_idx, slot, d);
        end
        checks++;
        if (sif.out_scalar !== expScalar) begin
          failures++;
          $display("[TB] FAIL scalar_data: got %h, required %h", sif.out_scalar, expScalar);
        end
        checks++;
        if (sif.out_last !== (beats == 511)) begin
          failures++;
          $display("[TB] FAIL scalar_last: last=%b on beat %0d, required %b",
                   sif.out_last, beats, (beats == 511));
        end
        if (beats == 39) begin
          checks++;
          if (sif.out_scalar[0] !== 32'h0207 || sif.out_scalar[1] !== 32'h0217 ||
              sif.out_scalar[2] !== 32'h0227 || sif.out_scalar[3] !== 32'h0237) begin
            failures++;
            $display("[TB] FAIL scalar_slot2_d7: got %h, required 00000237_00000227_00000217_00000207",
                     sif.out_scalar);
          end
        end
        beats++;
      end
      if (done) begin
        seenDone = 1'b1;
        doneCyc = cyc;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    checks++;
    if (!seenDone) begin
      failures++;
      $display("[TB] FAIL scalar_timeout: no done after %0d cycles, required done", cyc);
    end
    checks++;
    if (beats != 512 || reads != 32) begin
      failures++;
      $display("[TB] FAIL scalar_counts: beats=%0d reads=%0d, required 512/32", beats, reads);
    end
    checks++;
    if (doneCyc != 577) begin
      failures++;
      $display("[TB] FAIL scalar_latency: done at %0d, required 577", doneCyc);
    end
    @(negedge clk);
  endtask

  // Second start two cycles after the first must not restart the sweep
  task automatic test_back_to_back();
    int cyc, beats, doneCyc;
    bit seenDone, busyGap;
    cyc = 0; beats = 0; doneCyc = 0;
    seenDone = 1'b0;
    busyGap = 1'b0;
    isScalar = 1'b0;
    sif.out_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    cyc = 1;
    while (!seenDone && cyc < 400) begin
      start = (cyc == 2);
      if (sif.out_valid) beats++;
      if (!done && !busy) busyGap = 1'b1;
      if (done) begin
        seenDone = 1'b1;
        doneCyc = cyc;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    checks++;
    if (!seenDone || beats != 32 || doneCyc != 97) begin
      failures++;
      $display("[TB] FAIL b2b_drain: done=%b beats=%0d doneCyc=%0d, required 1/32/97",
               seenDone, beats, doneCyc);
    end
    checks++;
    if (busyGap) begin
      failures++;
      $display("[TB] FAIL b2b_busy: busy dropped mid-drain, required continuous");
    end
    beats = 0;
    repeat (20) begin
      @(negedge clk);
      if (sif.out_valid || busy || readEn) beats++;
    end
    checks++;
    if (beats != 0) begin
      failures++;
      $display("[TB] FAIL b2b_second_drain: %0d active cycles after done, required 0", beats);
    end
  endtask

  task automatic test_reset_mid_drain();
    int cyc, doneSeen;
    bit hit;
    cyc = 0; doneSeen = 0;
    hit = 1'b0;
    isScalar = 1'b1;
    sif.out_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!hit && cyc < 1000) begin
      if (sif.out_valid && sif.pe_idx == 5'd9 && sif.data_idx == 4'd4) hit = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("[TB] FAIL rstmid_reach: slot 9 beat 4 not seen, required seen");
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (sif.out_valid !== 1'b0 || busy !== 1'b0 || readEn !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rstmid_ctrl: valid=%b busy=%b rd=%b done=%b, required 0",
               sif.out_valid, busy, readEn, done);
    end
    checks++;
    if (sif.pe_idx !== 5'd0 || sif.data_idx !== 4'd0 || sif.out_scalar !== '0) begin
      failures++;
      $display("[TB] FAIL rstmid_idx: pe=%0d d=%0d, required 0/0", sif.pe_idx, sif.data_idx);
    end
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (done || busy || sif.out_valid) doneSeen++;
    end
    checks++;
    if (doneSeen != 0) begin
      failures++;
      $display("[TB] FAIL rstmid_no_done: %0d active cycles after reset, required 0", doneSeen);
    end
    isScalar = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!sif.out_valid && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (!sif.out_valid || sif.pe_idx !== 5'd0 || sif.data_idx !== 4'd0 ||
        sif.out_scalar[0] !== 32'h0000 || sif.out_scalar[3] !== 32'h0030) begin
      failures++;
      $display("[TB] FAIL rstmid_restart: valid=%b pe=%0d d=%0d s0=%h s3=%h, required 1/0/0/0/30",
               sif.out_valid, sif.pe_idx, sif.data_idx, sif.out_scalar[0], sif.out_scalar[3]);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Scenario sequence and summary
  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    start = 1'b0;
    isScalar = 1'b0;
    sif.out_ready = 1'b0;
    test_reset();
    test_wide_drain(-1);
    test_scalar_drain();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
